// File: rtl/pipe_trace_monitor.sv
// -----------------------------------------------------------------------------
// pipe_trace_monitor
//
// Passive pipeline-occupancy tracker that sits beside a MIPS core in a bench.
// It copies fetched instruction words through STAGES shadow stages and applies
// the same bubble-on-stall and kill-on-redirect rules as the core. This gives
// a per-stage view of the pipe and a retire stream. Saturating counters
// support CPI checks. The module only observes; it drives nothing in the core.
//
// Optional feature macro: PIPE_MON_CLASS_EN
//   When defined, five extra per-class retire counters are added. They are
//   decoded from the opcode of the retiring word: alu, load, store, branch
//   and jump.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : synchronous, active-low
//   fetch_instr  : instruction fetched this cycle
//   fetch_valid  : fetch_instr is a real instruction
//   stall        : load-use stall (stages 0..STALL_STAGE hold, bubble behind)
//   flush        : taken branch/jump (kills the FLUSH_DEPTH youngest in-flight)
//   clr_stats    : synchronous clear of the statistics counters only
//   stage_instr  : stage k word at [k*IW +: IW]
//   stage_valid  : bit k = stage k holds a real instruction
//   retire_valid : stage STAGES-1 valid
//   retire_instr : stage STAGES-1 word
//   cycle_cnt / retire_cnt / stall_cnt / flush_cnt : saturating statistics
//   alu_cnt / load_cnt / store_cnt / branch_cnt / jump_cnt : class counters
//                  (only with PIPE_MON_CLASS_EN)
// -----------------------------------------------------------------------------
module pipe_trace_monitor #(
  parameter int STAGES      = 5,
  parameter int IW          = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IW-1:0]        fetch_instr,
  input  logic                 fetch_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 clr_stats,
  output logic [STAGES*IW-1:0] stage_instr,
  output logic [STAGES-1:0]    stage_valid,
  output logic                 retire_valid,
  output logic [IW-1:0]        retire_instr,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`ifdef PIPE_MON_CLASS_EN
  ,
  output logic [CNT_W-1:0]     alu_cnt,
  output logic [CNT_W-1:0]     load_cnt,
  output logic [CNT_W-1:0]     store_cnt,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     jump_cnt
`endif
);

  // Elaboration-time parameter legality checks.
  if (STAGES < 3 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "pipe_trace_monitor: STAGES must be in 3..8");
  end
  if (STALL_STAGE < 0 || STALL_STAGE + 1 >= STAGES) begin : g_bad_stall
    $fatal(1, "pipe_trace_monitor: STALL_STAGE+1 must be < STAGES");
  end
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH >= STAGES) begin : g_bad_flush
    $fatal(1, "pipe_trace_monitor: FLUSH_DEPTH must be in 1..STAGES-1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $fatal(1, "pipe_trace_monitor: CNT_W must be >= 1");
  end
`ifdef PIPE_MON_CLASS_EN
  if (IW < 32) begin : g_bad_iw
    $fatal(1, "pipe_trace_monitor: class decode needs IW >= 32");
  end
`endif

  // ---------------------------------------------------------------------------
  // Shadow pipe
  // ---------------------------------------------------------------------------
  logic [IW-1:0]     instr_q [STAGES];
  logic [IW-1:0]     instr_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Priority: flush over stall over normal advance.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      instr_d[k] = instr_q[k];
    end
    valid_d = valid_q;

    if (flush) begin
      valid_d[0] = fetch_valid;
      instr_d[0] = fetch_instr;
      for (int k = 1; k < STAGES; k++) begin
        if (k <= FLUSH_DEPTH) begin
          // Redirect kills the wrong-path words that would enter these slots.
          valid_d[k] = 1'b0;
          instr_d[k] = '0;
        end else begin
          valid_d[k] = valid_q[k-1];
          instr_d[k] = instr_q[k-1];
        end
      end
    end else if (stall) begin
      for (int k = 1; k < STAGES; k++) begin
        if (k == STALL_STAGE + 1) begin
          // One bubble per stalled edge enters just behind the held stages.
          valid_d[k] = 1'b0;
          instr_d[k] = '0;
        end else if (k > STALL_STAGE + 1) begin
          valid_d[k] = valid_q[k-1];
          instr_d[k] = instr_q[k-1];
        end
      end
    end else begin
      valid_d[0] = fetch_valid;
      instr_d[0] = fetch_instr;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        instr_d[k] = instr_q[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= instr_d[k];
      end
    end
  end

  always_comb begin
    stage_instr = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_instr[k*IW +: IW] = instr_q[k];
    end
  end

  assign stage_valid  = valid_q;
  assign retire_valid = valid_q[STAGES-1];
  assign retire_instr = instr_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Retire is judged on the pre-edge content of the last stage.
  logic retire_fire;
  logic stall_mode;
  assign retire_fire = valid_q[STAGES-1];
  assign stall_mode  = stall & ~flush;

  logic [CNT_W-1:0] cycle_q, retire_q, stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (!reset || clr_stats) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      cycle_q  <= sat_inc(cycle_q, 1'b1);
      retire_q <= sat_inc(retire_q, retire_fire);
      stall_q  <= sat_inc(stall_q, stall_mode);
      flush_q  <= sat_inc(flush_q, flush);
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

`ifdef PIPE_MON_CLASS_EN
  // ---------------------------------------------------------------------------
  // Per-class retire counters (opcode field of the retiring word)
  // ---------------------------------------------------------------------------
  logic [5:0] ret_op;
  logic       is_alu, is_load, is_store, is_branch, is_jump;
  assign ret_op    = instr_q[STAGES-1][31:26];
  assign is_alu    = retire_fire && (ret_op == 6'b000000 || ret_op == 6'b001000);
  assign is_load   = retire_fire && (ret_op == 6'b100011);
  assign is_store  = retire_fire && (ret_op == 6'b101011);
  assign is_branch = retire_fire && (ret_op == 6'b000100 || ret_op == 6'b000101);
  assign is_jump   = retire_fire && (ret_op == 6'b000010);

  logic [CNT_W-1:0] alu_q, load_q, store_q, branch_q, jump_q;

  always_ff @(posedge clock) begin
    if (!reset || clr_stats) begin
      alu_q    <= '0;
      load_q   <= '0;
      store_q  <= '0;
      branch_q <= '0;
      jump_q   <= '0;
    end else begin
      alu_q    <= sat_inc(alu_q, is_alu);
      load_q   <= sat_inc(load_q, is_load);
      store_q  <= sat_inc(store_q, is_store);
      branch_q <= sat_inc(branch_q, is_branch);
      jump_q   <= sat_inc(jump_q, is_jump);
    end
  end

  assign alu_cnt    = alu_q;
  assign load_cnt   = load_q;
  assign store_cnt  = store_q;
  assign branch_cnt = branch_q;
  assign jump_cnt   = jump_q;
`endif

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// -----------------------------------------------------------------------------
// Bench for pipe_trace_monitor. Two instances share the stimulus: the default
// configuration and a CNT_W=4 copy used to exercise counter saturation.
// A behavioural model steps an array-of-stages view of the pipe and plain
// integer counts; saturation is applied only when comparing.
// -----------------------------------------------------------------------------
module tb_pipe_trace_monitor;
  localparam int S   = 5;
  localparam int IW  = 32;
  localparam int CW  = 16;
  localparam int CW4 = 4;
  localparam int SS  = 1;
  localparam int FD  = 2;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] fetch_instr = '0;
  logic          fetch_valid = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          clr_stats = 1'b0;

  always #5 clock = ~clock;

  logic [S*IW-1:0] stage_instr, stage_instr4;
  logic [S-1:0]    stage_valid, stage_valid4;
  logic            retire_valid, retire_valid4;
  logic [IW-1:0]   retire_instr, retire_instr4;
  logic [CW-1:0]   cycle_cnt, retire_cnt, stall_cnt, flush_cnt;
  logic [CW4-1:0]  cycle_cnt4, retire_cnt4, stall_cnt4, flush_cnt4;
`ifdef PIPE_MON_CLASS_EN
  logic [CW-1:0]   alu_cnt, load_cnt, store_cnt, branch_cnt, jump_cnt;
  logic [CW4-1:0]  alu_cnt4, load_cnt4, store_cnt4, branch_cnt4, jump_cnt4;
`endif

  pipe_trace_monitor #(.STAGES(S), .IW(IW), .CNT_W(CW), .STALL_STAGE(SS),
                       .FLUSH_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
    .clr_stats(clr_stats), .stage_instr(stage_instr), .stage_valid(stage_valid),
    .retire_valid(retire_valid), .retire_instr(retire_instr),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`ifdef PIPE_MON_CLASS_EN
    , .alu_cnt(alu_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt),
    .branch_cnt(branch_cnt), .jump_cnt(jump_cnt)
`endif
  );

  pipe_trace_monitor #(.STAGES(S), .IW(IW), .CNT_W(CW4), .STALL_STAGE(SS),
                       .FLUSH_DEPTH(FD)) dut4 (
    .clock(clock), .reset(reset), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
    .clr_stats(clr_stats), .stage_instr(stage_instr4), .stage_valid(stage_valid4),
    .retire_valid(retire_valid4), .retire_instr(retire_instr4),
    .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4), .stall_cnt(stall_cnt4),
    .flush_cnt(flush_cnt4)
`ifdef PIPE_MON_CLASS_EN
    , .alu_cnt(alu_cnt4), .load_cnt(load_cnt4), .store_cnt(store_cnt4),
    .branch_cnt(branch_cnt4), .jump_cnt(jump_cnt4)
`endif
  );

  // ---------------- reference model ----------------
  logic          m_v [S];
  logic [IW-1:0] m_i [S];
  int            n_cyc, n_ret, n_stl, n_fl;
  int            n_cls [5];   // alu, load, store, branch, jump
  logic [IW-1:0] exp_q [$];   // retire scoreboard
  int            checks = 0;
  int            errors = 0;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000: return 0;
      6'b100011:            return 1;
      6'b101011:            return 2;
      6'b000100, 6'b000101: return 3;
      6'b000010:            return 4;
      default:              return -1;
    endcase
  endfunction

  function automatic logic [IW-1:0] dut_stage(input int k);
    return stage_instr[k*IW +: IW];
  endfunction

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_edge();
    logic       rv;
    logic [5:0] op;
    int         c;
    if (!reset) begin
      for (int k = 0; k < S; k++) begin m_v[k] = 1'b0; m_i[k] = '0; end
      n_cyc = 0; n_ret = 0; n_stl = 0; n_fl = 0;
      for (int j = 0; j < 5; j++) n_cls[j] = 0;
    end else begin
      rv = m_v[S-1];
      op = m_i[S-1][31:26];
      if (flush) begin
        for (int k = S-1; k > FD; k--) begin m_v[k] = m_v[k-1]; m_i[k] = m_i[k-1]; end
        for (int k = 1; k <= FD; k++) begin m_v[k] = 1'b0; m_i[k] = '0; end
        m_v[0] = fetch_valid; m_i[0] = fetch_instr;
      end else if (stall) begin
        for (int k = S-1; k > SS+1; k--) begin m_v[k] = m_v[k-1]; m_i[k] = m_i[k-1]; end
        m_v[SS+1] = 1'b0; m_i[SS+1] = '0;
      end else begin
        for (int k = S-1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_i[k] = m_i[k-1]; end
        m_v[0] = fetch_valid; m_i[0] = fetch_instr;
      end
      if (clr_stats) begin
        n_cyc = 0; n_ret = 0; n_stl = 0; n_fl = 0;
        for (int j = 0; j < 5; j++) n_cls[j] = 0;
      end else begin
        n_cyc++;
        if (rv) begin
          n_ret++;
          c = classify(op);
          if (c >= 0) n_cls[c]++;
        end
        if (flush) n_fl++;
        else if (stall) n_stl++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fv, input logic [IW-1:0] fi, input logic st,
                       input logic fl, input logic clr);
    fetch_valid = fv; fetch_instr = fi; stall = st; flush = fl; clr_stats = clr;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic stream(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      drive(1'b1, IW'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (stage_valid !== '0 || stage_instr !== '0) begin
      errors++;
      $display("FAIL reset_pipe valid=%b instr=%h want 0", stage_valid, stage_instr);
    end
    checks++;
    if (cycle_cnt !== '0 || retire_cnt !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d %0d %0d %0d want 0", cycle_cnt, retire_cnt,
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, IW'(k), 1'b0, 1'b0, 1'b0);
      tick();
      if (k >= 5) begin
        checks++;
        if (retire_valid !== 1'b1 || retire_instr !== IW'(k - 4)) begin
          errors++;
          $display("FAIL stream_retire edge %0d got %b/%0d want 1/%0d", k,
                   retire_valid, retire_instr, k - 4);
        end
      end
    end
    // Retires counted on edges 6..10 (pre-edge last stage valid).
    checks++;
    if (cycle_cnt !== 16'd10 || retire_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stream_cnt cycle=%0d retire=%0d want 10/5", cycle_cnt, retire_cnt);
    end
  endtask

  task automatic test_stall();
    int gaps;
    do_reset();
    stream(1, 7);
    drive(1'b1, 32'd8, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (dut_stage(0) !== 32'd7 || dut_stage(1) !== 32'd6 || stage_valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL stall_hold s0=%0d s1=%0d v=%b want 7,6,11", dut_stage(0),
               dut_stage(1), stage_valid[1:0]);
    end
    checks++;
    if (stage_valid[2] !== 1'b0 || dut_stage(2) !== '0 || dut_stage(3) !== 32'd5) begin
      errors++;
      $display("FAIL stall_bubble v2=%b s2=%0d s3=%0d want 0,0,5", stage_valid[2],
               dut_stage(2), dut_stage(3));
    end
    checks++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt got %0d/%0d want 1/0", stall_cnt, flush_cnt);
    end
    gaps = 0;
    for (int k = 8; k <= 13; k++) begin
      drive(1'b1, IW'(k), 1'b0, 1'b0, 1'b0);
      tick();
      if (!retire_valid) gaps++;
      checks++;
      if (retire_valid !== m_v[S-1] || retire_instr !== m_i[S-1]) begin
        errors++;
        $display("FAIL stall_seq got %b/%0d want %b/%0d", retire_valid, retire_instr,
                 m_v[S-1], m_i[S-1]);
      end
    end
    checks++;
    if (gaps != 1) begin
      errors++;
      $display("FAIL stall_gap got %0d want 1", gaps);
    end
  endtask

  task automatic test_flush();
    logic bad;
    do_reset();
    stream(1, 9);
    drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (dut_stage(0) !== 32'h40 || stage_valid !== 5'b11001 ||
        dut_stage(3) !== 32'd7 || dut_stage(4) !== 32'd6) begin
      errors++;
      $display("FAIL flush_pipe s0=%h v=%b s3=%0d s4=%0d want 40,11001,7,6",
               dut_stage(0), stage_valid, dut_stage(3), dut_stage(4));
    end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_cnt got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, IW'(32'h100 + k), 1'b0, 1'b0, 1'b0);
      tick();
      if (retire_valid && (retire_instr == 32'd8 || retire_instr == 32'd9)) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill got killed word retiring=%b want 0", bad);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    stream(1, 5);
    drive(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL both_cnt flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
    checks++;
    if (dut_stage(0) !== 32'h55 || stage_valid !== 5'b11001 || dut_stage(3) !== 32'd3) begin
      errors++;
      $display("FAIL both_pipe s0=%h v=%b s3=%0d want 55,11001,3", dut_stage(0),
               stage_valid, dut_stage(3));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    stream(1, 20);
    checks++;
    if (cycle_cnt4 !== 4'd15 || retire_cnt4 !== 4'd15 || cycle_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_cnt c4=%0d r4=%0d c=%0d want 15,15,20", cycle_cnt4,
               retire_cnt4, cycle_cnt);
    end
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (cycle_cnt !== '0 || retire_cnt !== '0 || cycle_cnt4 !== '0 || retire_cnt4 !== '0) begin
      errors++;
      $display("FAIL clr_cnt got %0d %0d %0d %0d want 0", cycle_cnt, retire_cnt,
               cycle_cnt4, retire_cnt4);
    end
    checks++;
    if (dut_stage(0) !== 32'h77 || dut_stage(1) !== 32'd20 || retire_instr !== 32'd17) begin
      errors++;
      $display("FAIL clr_pipe s0=%h s1=%0d ret=%0d want 77,20,17", dut_stage(0),
               dut_stage(1), retire_instr);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    do_reset();
    stream(1, 4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (stage_valid !== '0 || cycle_cnt !== '0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL midrst got v=%b c=%0d r=%0d want 0", stage_valid, cycle_cnt, retire_cnt);
    end
    drive(1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    lat = 0;
    while (!retire_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || retire_instr !== 32'hAB) begin
      errors++;
      $display("FAIL midrst_lat got %0d/%h want 4/ab", lat, retire_instr);
    end
  endtask

  task automatic test_random();
    logic [S-1:0]  ev;
    logic [IW-1:0] w;
    logic [5:0]    ops [7];
    ops[0] = 6'b000000; ops[1] = 6'b001000; ops[2] = 6'b100011; ops[3] = 6'b101011;
    ops[4] = 6'b000100; ops[5] = 6'b000010; ops[6] = 6'b111111;
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 6)];
      drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
      tick();
      if (m_v[S-1]) exp_q.push_back(m_i[S-1]);
      if (retire_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_retire_extra n=%0d got %h", n, retire_instr);
        end else begin
          w = exp_q.pop_front();
          if (retire_instr !== w) begin
            errors++;
            $display("FAIL rnd_retire n=%0d got %h want %h", n, retire_instr, w);
          end
        end
      end
      for (int k = 0; k < S; k++) ev[k] = m_v[k];
      checks++;
      if (stage_valid !== ev) begin
        errors++;
        $display("FAIL rnd_valid n=%0d got %b want %b", n, stage_valid, ev);
      end
      for (int k = 0; k < S; k++) begin
        checks++;
        if (dut_stage(k) !== m_i[k]) begin
          errors++;
          $display("FAIL rnd_stage%0d n=%0d got %h want %h", k, n, dut_stage(k), m_i[k]);
        end
      end
      checks++;
      if (cycle_cnt !== CW'(sat(n_cyc, CW)) || retire_cnt !== CW'(sat(n_ret, CW)) ||
          stall_cnt !== CW'(sat(n_stl, CW)) || flush_cnt !== CW'(sat(n_fl, CW))) begin
        errors++;
        $display("FAIL rnd_cnt n=%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", n,
                 cycle_cnt, retire_cnt, stall_cnt, flush_cnt, n_cyc, n_ret, n_stl, n_fl);
      end
      checks++;
      if (cycle_cnt4 !== CW4'(sat(n_cyc, CW4)) || retire_cnt4 !== CW4'(sat(n_ret, CW4)) ||
          stall_cnt4 !== CW4'(sat(n_stl, CW4)) || flush_cnt4 !== CW4'(sat(n_fl, CW4))) begin
        errors++;
        $display("FAIL rnd_cnt4 n=%0d got %0d %0d %0d %0d", n, cycle_cnt4, retire_cnt4,
                 stall_cnt4, flush_cnt4);
      end
`ifdef PIPE_MON_CLASS_EN
      checks++;
      if (alu_cnt !== CW'(sat(n_cls[0], CW)) || load_cnt !== CW'(sat(n_cls[1], CW)) ||
          store_cnt !== CW'(sat(n_cls[2], CW)) || branch_cnt !== CW'(sat(n_cls[3], CW)) ||
          jump_cnt !== CW'(sat(n_cls[4], CW))) begin
        errors++;
        $display("FAIL rnd_class n=%0d got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d",
                 n, alu_cnt, load_cnt, store_cnt, branch_cnt, jump_cnt,
                 n_cls[0], n_cls[1], n_cls[2], n_cls[3], n_cls[4]);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_stall_flush();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
